// File: rtl/btn_cmd_queue.sv
// btn_cmd_queue: debounced pushbuttons feeding a 2-entry direction FIFO drained by game ticks
module btn_cmd_queue #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic       tick,
  output logic [4:0] btn_cmd,
  output logic [1:0] q_count,
  output logic       dropped
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [4:0] s1_q, s2_q, lvl_q, lvl_d, rise;
  logic [4:0][CNT_W-1:0] db_q, db_d;
  logic [1:0] e0_q, e0_d, e1_q, e1_d, last_q, last_d, qn_q, qn_d;
  logic [1:0] e0p, qnp, cand, newest;
  logic [3:0] dir_q, dir_d;
  logic r0_q, drop_q, drop_d, pop, has, take, push;
  // per-bit debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_d = db_q;
    lvl_d = lvl_q;
    rise = '0;
    for (int k = 0; k < 5; k++) begin
      db_d[k] = (s2_q[k] == lvl_q[k] || db_q[k] == LAST) ? '0 : db_q[k] + 1'b1;
      lvl_d[k] = (s2_q[k] != lvl_q[k] && db_q[k] == LAST) ? s2_q[k] : lvl_q[k];
      rise[k] = lvl_d[k] & ~lvl_q[k];
    end
  end
  // FIFO: pop first, then push against the post-pop contents; restart flushes everything
  always_comb begin
    pop = tick && qn_q != 2'd0;
    e0p = pop ? e1_q : e0_q;
    qnp = qn_q - 2'(pop);
    last_d = pop ? e0_q : last_q;
    has = |rise[4:1] && !lvl_q[0];
    cand = rise[1] ? 2'd3 : rise[2] ? 2'd2 : rise[3] ? 2'd0 : 2'd1;
    newest = qnp == 2'd0 ? last_d : qnp == 2'd1 ? e0p : e1_q;
    take = has && cand != newest;
    push = take && qnp != 2'd2;
    e0_d = (push && qnp == 2'd0) ? cand : e0p;
    e1_d = (push && qnp == 2'd1) ? cand : e1_q;
    qn_d = qnp + 2'(push);
    drop_d = drop_q | (take && qnp == 2'd2);
    dir_d = tick ? (pop ? {e0_q == 2'd1, e0_q == 2'd0, e0_q == 2'd2, e0_q == 2'd3} : 4'd0) : dir_q;
    if (lvl_q[0]) begin
      qn_d = 2'd0;
      drop_d = 1'b0;
      last_d = 2'd0;
      dir_d = 4'd0;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      lvl_q <= '0;
      db_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
      qn_q <= '0;
      last_q <= '0;
      dir_q <= '0;
      r0_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
      lvl_q <= lvl_d;
      db_q <= db_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      qn_q <= qn_d;
      last_q <= last_d;
      dir_q <= dir_d;
      r0_q <= lvl_q[0];
      drop_q <= drop_d;
    end
  end
  assign btn_cmd = {dir_q, r0_q};
  assign q_count = qn_q;
  assign dropped = drop_q;
endmodule

// File: tb/tb_btn_cmd_queue.sv
// tb_btn_cmd_queue: directed and random stimulus checked against a queue-based reference model
module tb_btn_cmd_queue;
  localparam int DEB = 4;
  logic clk = 0, rst = 0, tick = 0;
  logic [4:0] btn_raw = '0, btn_cmd;
  logic [1:0] q_count;
  logic dropped;
  int checks = 0, errors = 0;
  bit [4:0] md1, md2, mlvl, mcmd;
  int mrun[5];
  int mq[$];
  int mlast;
  bit mdrop;
  int code[5] = '{0, 3, 2, 0, 1};

  btn_cmd_queue #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .tick(tick),
    .btn_cmd(btn_cmd), .q_count(q_count), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model;
    bit [4:0] syn, press;
    bit old_restart;
    int c, nw;
    if (!rst) begin
      md1 = 0; md2 = 0; mlvl = 0; mcmd = 0; mlast = 0; mdrop = 0;
      mq.delete();
      foreach (mrun[k]) mrun[k] = 0;
      return;
    end
    syn = md2; md2 = md1; md1 = btn_raw;
    old_restart = mlvl[0];
    press = 0;
    for (int k = 0; k < 5; k++) begin
      if (syn[k] != mlvl[k]) begin
        mrun[k]++;
        if (mrun[k] == DEB) begin
          mlvl[k] = syn[k];
          mrun[k] = 0;
          press[k] = syn[k];
        end
      end else mrun[k] = 0;
    end
    mcmd[0] = old_restart;
    if (old_restart) begin
      mq.delete(); mlast = 0; mdrop = 0; mcmd[4:1] = 0;
      return;
    end
    if (tick) begin
      if (mq.size() > 0) begin
        mlast = mq.pop_front();
        mcmd[4:1] = 4'b0000;
        mcmd[mlast == 3 ? 1 : mlast == 2 ? 2 : mlast == 0 ? 3 : 4] = 1'b1;
      end else mcmd[4:1] = 0;
    end
    c = -1;
    for (int k = 1; k < 5; k++) if (press[k] && c < 0) c = code[k];
    if (c >= 0) begin
      nw = mq.size() > 0 ? mq[$] : mlast;
      if (c != nw) begin
        if (mq.size() < 2) mq.push_back(c);
        else mdrop = 1;
      end
    end
  endtask

  task automatic step(input logic [4:0] r, input logic t, input logic rn);
    btn_raw = r; tick = t; rst = rn;
    @(posedge clk);
    model();
    #1;
    chk("btn_cmd", btn_cmd, mcmd);
    chk("q_count", {3'b0, q_count}, 5'(mq.size()));
    chk("dropped", {4'b0, dropped}, {4'b0, mdrop});
  endtask

  task automatic press_btn(input int b);
    for (int k = 0; k < 8; k++) step(5'(1 << b), 0, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
  endtask

  task automatic do_reset;
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    do_reset();
    chk("reset_cmd", btn_cmd, 5'b00000);
    chk("reset_qc", {3'b0, q_count}, 5'd0);
    for (int k = 0; k < 3; k++) step(5'b00010, 0, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    chk("glitch_qc", {3'b0, q_count}, 5'd0);
    press_btn(1);
    chk("up_qc", {3'b0, q_count}, 5'd1);
    step(0, 1, 1);
    chk("up_cmd", btn_cmd, 5'b00010);
    chk("up_qc0", {3'b0, q_count}, 5'd0);
    do_reset();
    press_btn(1); press_btn(2); press_btn(4);
    chk("full_qc", {3'b0, q_count}, 5'd2);
    chk("full_drop", {4'b0, dropped}, 5'd1);
    step(0, 1, 1); chk("pop1", btn_cmd, 5'b00010);
    step(0, 1, 1); chk("pop2", btn_cmd, 5'b00100);
    step(0, 1, 1); chk("pop3", btn_cmd, 5'b00000);
    do_reset();
    press_btn(2); press_btn(4);
    for (int k = 0; k < 8; k++) step(5'b01000, k == 5, 1);
    for (int k = 0; k < 8; k++) step(0, 0, 1);
    chk("pushpop_qc", {3'b0, q_count}, 5'd2);
    chk("pushpop_drop", {4'b0, dropped}, 5'd0);
    do_reset();
    press_btn(3);
    chk("right_dup_qc", {3'b0, q_count}, 5'd0);
    press_btn(1); press_btn(2);
    for (int k = 0; k < 8; k++) step(5'b00001, 0, 1);
    chk("restart_qc", {3'b0, q_count}, 5'd0);
    chk("restart_cmd", btn_cmd, 5'b00001);
    for (int k = 0; k < 3; k++) step(5'b00011, 0, 1);
    step(5'b00011, 0, 0);
    chk("rst_cmd", btn_cmd, 5'b00000);
    chk("rst_qc", {3'b0, q_count}, 5'd0);
    chk("rst_drop", {4'b0, dropped}, 5'd0);
    begin
      logic [4:0] r;
      r = 0;
      for (int n = 0; n < 4000; n++) begin
        for (int k = 1; k < 5; k++) if ($urandom_range(0, 9) == 0) r[k] = ~r[k];
        if ($urandom_range(0, 59) == 0) r[0] = ~r[0];
        step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 499) != 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
